// File: rtl/instr_mem.sv
// instr_mem: instruction memory with programmable wait states, a one-cycle valid strobe and a write port
module instr_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [DATA_W-1:0] mem_t [DEPTH];
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic mem_t init_mem();
    mem_t m;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'(i);
      m[i] = DATA_W'({a, ~a});
    end
    return m;
  endfunction
  mem_t mem = init_mem();
  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, rd_addr;
  logic accept;
  always_comb begin
    accept  = req && state != WAIT;
    rd_addr = accept ? instr_addr : addr_q;
    nxt     = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_nxt = accept ? 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1) :
              (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // the read uses the pre-edge array, so a write on the capture edge is not returned
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      instr  <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) addr_q <= instr_addr;
      if (nxt == RESP) instr <= mem[rd_addr];
    end
  assign instr_valid = state == RESP;
  assign busy        = state == WAIT;
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: randomized and directed checks of instr_mem against a timing-level reference model
module tb_instr_mem;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, req = 0, wr_en = 0;
  logic [7:0] instr_addr = 0, wr_addr = 0;
  logic [15:0] wr_data = 0, instr;
  logic instr_valid, busy;
  logic rst0 = 1, req0 = 0;
  logic [7:0] addr0 = 0;
  logic [15:0] instr0;
  logic valid0, busy0;
  instr_mem #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .instr_addr(instr_addr), .instr(instr),
    .instr_valid(instr_valid), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  instr_mem #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .instr_addr(addr0), .instr(instr0),
    .instr_valid(valid0), .busy(busy0), .wr_en(1'b0), .wr_addr(8'h00), .wr_data(16'h0000));
  int checks = 0, errors = 0;
  localparam int W = 2;
  logic [15:0] ref_mem [256];
  bit pend = 0;
  logic [7:0] p_addr;
  int due = 0, k = 0;
  logic exp_valid = 0, exp_busy = 0;
  logic [15:0] exp_instr = 0;
  // model: a request accepted at edge N is captured at edge N+W; requests at edges N+1..N+W are ignored
  task automatic tick();
    exp_valid = 0;
    if (rst) begin
      pend = 0;
      exp_instr = 0;
    end else begin
      if (req && (!pend || k > due)) begin
        pend = 1;
        p_addr = instr_addr;
        due = k + W;
      end
      if (pend && k == due) begin
        exp_instr = ref_mem[p_addr];
        exp_valid = 1;
      end
    end
    exp_busy = pend && k < due;
    if (wr_en) ref_mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    k++;
  endtask
  task automatic test_reset();
    rst = 1; req = 1; instr_addr = 8'h05;
    repeat (2) begin
      tick();
      checks++;
      if ({instr_valid, busy, instr} !== {1'b0, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset: valid=%b busy=%b instr=%h, want 0 0 0000", instr_valid, busy, instr);
      end
    end
    rst = 0; req = 0;
    tick();
  endtask
  task automatic test_single_fetch();
    for (int i = 0; i < 4; i++) begin
      req = i == 0;
      instr_addr = i == 0 ? 8'h05 : 8'($urandom);
      tick();
      checks++;
      if ({instr_valid, busy, instr} !== {exp_valid, exp_busy, exp_instr}) begin
        errors++;
        $display("FAIL single[%0d]: valid=%b busy=%b instr=%h, want %b %b %h", i, instr_valid, busy, instr, exp_valid, exp_busy, exp_instr);
      end
      if (i == 2) begin
        checks++;
        if (instr !== 16'h05FA || instr_valid !== 1'b1) begin
          errors++;
          $display("FAIL single_data: instr=%h valid=%b, want 05FA 1", instr, instr_valid);
        end
      end
    end
  endtask
  task automatic test_write_read();
    wr_en = 1; wr_addr = 8'h10; wr_data = 16'h1234;
    tick();
    wr_en = 0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) begin
        req = i == 0;
        instr_addr = 8'h10;
        wr_en = j == 1 && i == 2;
        wr_data = 16'hBEEF;
        tick();
        wr_en = 0;
        checks++;
        if ({instr_valid, busy, instr} !== {exp_valid, exp_busy, exp_instr}) begin
          errors++;
          $display("FAIL write_read[%0d.%0d]: valid=%b busy=%b instr=%h, want %b %b %h", j, i, instr_valid, busy, instr, exp_valid, exp_busy, exp_instr);
        end
        if (i == 2) begin
          checks++;
          if (instr !== (j < 2 ? 16'h1234 : 16'hBEEF)) begin
            errors++;
            $display("FAIL write_read_data[%0d]: instr=%h, want %h", j, instr, j < 2 ? 16'h1234 : 16'hBEEF);
          end
        end
      end
  endtask
  task automatic test_back_to_back();
    logic [7:0] addrs [10] = '{8'h01, 8'h77, 8'h77, 8'h02, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       reqs  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      req = reqs[i];
      instr_addr = addrs[i];
      tick();
      nvalid += int'(instr_valid);
      checks++;
      if ({instr_valid, busy, instr} !== {exp_valid, exp_busy, exp_instr}) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b busy=%b instr=%h, want %b %b %h", i, instr_valid, busy, instr, exp_valid, exp_busy, exp_instr);
      end
      if (i == 2 || i == 5) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== (i == 2 ? 16'h01FE : 16'h02FD)) begin
          errors++;
          $display("FAIL b2b_data[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instr, i == 2 ? 16'h01FE : 16'h02FD);
        end
      end
    end
    checks++;
    if (nvalid != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d responses, want 2", nvalid);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      req = i == 0 || i == 5;
      instr_addr = 8'h20;
      rst = i == 1;
      tick();
      rst = 0;
      checks++;
      if ({instr_valid, busy, instr} !== {exp_valid, exp_busy, exp_instr}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: valid=%b busy=%b instr=%h, want %b %b %h", i, instr_valid, busy, instr, exp_valid, exp_busy, exp_instr);
      end
      if (i < 5) begin
        checks++;
        if (instr_valid !== 1'b0 || (i >= 1 && instr !== 16'h0000)) begin
          errors++;
          $display("FAIL reset_mid_abort[%0d]: valid=%b instr=%h, want 0 0000", i, instr_valid, instr);
        end
      end
      if (i == 7) begin
        checks++;
        if (instr !== 16'h20DF) begin
          errors++;
          $display("FAIL reset_mid_data: instr=%h, want 20DF", instr);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(99) < 3;
      req = $urandom_range(1);
      instr_addr = 8'($urandom_range(7));
      wr_en = $urandom_range(3) == 0;
      wr_addr = 8'($urandom_range(7));
      wr_data = 16'($urandom);
      tick();
      checks++;
      if ({instr_valid, busy, instr} !== {exp_valid, exp_busy, exp_instr}) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b busy=%b instr=%h, want %b %b %h", i, instr_valid, busy, instr, exp_valid, exp_busy, exp_instr);
      end
    end
    rst = 0; req = 0; wr_en = 0;
    repeat (4) tick();
  endtask
  task automatic test_wait0();
    logic [7:0] a;
    rst0 = 1;
    tick();
    rst0 = 0;
    for (int i = 0; i < 5; i++) begin
      req0 = i < 4;
      addr0 = 8'(i);
      tick();
      a = 8'(i);
      checks++;
      if (i < 4 ? ({valid0, busy0, instr0} !== {1'b1, 1'b0, a, ~a}) : ({valid0, busy0} !== 2'b00)) begin
        errors++;
        $display("FAIL wait0[%0d]: valid=%b busy=%b instr=%h, want %b 0 %h", i, valid0, busy0, instr0, i < 4, {a, ~a});
      end
    end
    req0 = 0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = {8'(i), ~8'(i)};
    test_reset();
    test_single_fetch();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
